// File: rtl/maga_poll_ctrl.sv
// Magnetometer link sequencer: powers the sensor, polls it over the shared UART, checks the reply
// and streams it to the host path.
// state   | meaning
// OFF     | sensor unpowered, waiting for enable
// PWRUP   | sensor powered, waiting for READY
// IDLE    | poll interval running
// SEND    | issue command byte once tx core is free
// WAIT_TX | wait for tx busy to rise and then fall
// RECV    | collect reply bytes with running XOR
// CHECK   | compare checksum and sensor status
// STREAM  | emit reply bytes, one per cycle
// FAULT   | sensor unpowered for the hold time before retry
module maga_poll_ctrl #(
    parameter int unsigned PWRUP_TO   = 5_000_000,
    parameter int unsigned POLL_CYC   = 2_500_000,
    parameter int unsigned RESP_TO    = 1_000_000,
    parameter int unsigned RESP_LEN   = 4,
    parameter logic [7:0]  CMD_BYTE   = 8'hA5,
    parameter int unsigned FAULT_HOLD = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       maga_ready,
    input  logic       maga_flt,
    input  logic       maga_invalid,
    output logic       maga_en,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       out_last,
    output logic       gd,
    output logic [1:0] err
);
    localparam int unsigned T_A   = (PWRUP_TO > POLL_CYC) ? PWRUP_TO : POLL_CYC;
    localparam int unsigned T_B   = (RESP_TO > FAULT_HOLD) ? RESP_TO : FAULT_HOLD;
    localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int unsigned TW    = $clog2(T_MAX);
    localparam int unsigned CW    = $clog2(RESP_LEN + 1);
    localparam int          LEN   = int'(RESP_LEN);

    localparam logic [TW-1:0] LD_PWRUP = TW'(PWRUP_TO - 1);
    localparam logic [TW-1:0] LD_POLL  = TW'(POLL_CYC - 1);
    localparam logic [TW-1:0] LD_RESP  = TW'(RESP_TO - 1);
    localparam logic [TW-1:0] LD_FAULT = TW'(FAULT_HOLD - 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(RESP_LEN - 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_READY = 2'd1;
    localparam logic [1:0] ERR_RESP  = 2'd2;
    localparam logic [1:0] ERR_FRAME = 2'd3;

    typedef enum logic [3:0] {
        S_OFF, S_PWRUP, S_IDLE, S_SEND, S_WAIT_TX, S_RECV, S_CHECK, S_STREAM, S_FAULT
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [CW-1:0] count, count_nx;
    logic [7:0]    chk_acc, chk_nx;
    logic [7:0]    rx_buf [RESP_LEN];
    logic          buf_we;
    logic          flt_seen, flt_seen_nx;
    logic          busy_seen, busy_seen_nx;
    logic          gd_nx;
    logic [1:0]    err_nx;
    logic [1:0]    ready_sy, flt_sy, inv_sy;
    logic          ready_s, flt_s, inv_s, tc, powered, good;

    assign ready_s = ready_sy[1];
    assign flt_s   = flt_sy[1];
    assign inv_s   = inv_sy[1];
    assign tc      = (timer == '0);
    assign powered = (state != S_OFF) && (state != S_FAULT);
    assign good    = (rx_buf[LAST_IDX] == chk_acc) && !inv_s && !flt_seen;

    assign out_valid = (state == S_STREAM);
    assign out_last  = out_valid && (count == LAST_IDX) && !flt_s && enable;
    assign data_out  = out_valid ? rx_buf[count] : 8'h00;
    assign tx_data   = tx_start ? CMD_BYTE : 8'h00;

    always_comb begin
        state_nx     = state;
        timer_nx     = tc ? '0 : timer - 1'b1;
        count_nx     = count;
        chk_nx       = chk_acc;
        buf_we       = 1'b0;
        flt_seen_nx  = flt_seen | flt_s;
        busy_seen_nx = busy_seen;
        gd_nx        = gd;
        err_nx       = err;
        tx_start     = 1'b0;
        if (powered && flt_s) begin
            state_nx = S_FAULT;
            timer_nx = LD_FAULT;
            gd_nx    = 1'b0;
        end else if (!enable) begin
            state_nx = S_OFF;
            gd_nx    = 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nx = S_PWRUP;
                    timer_nx = LD_PWRUP;
                end
                S_PWRUP: begin
                    if (ready_s) begin
                        state_nx = S_IDLE;
                        timer_nx = '0;
                    end else if (tc) begin
                        state_nx = S_FAULT;
                        timer_nx = LD_FAULT;
                        err_nx   = ERR_READY;
                        gd_nx    = 1'b0;
                    end
                end
                S_IDLE: begin
                    if (tc) begin
                        state_nx    = S_SEND;
                        flt_seen_nx = 1'b0;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start     = 1'b1;
                        state_nx     = S_WAIT_TX;
                        timer_nx     = LD_RESP;
                        busy_seen_nx = 1'b0;
                    end
                end
                S_WAIT_TX: begin
                    // the response timer also guards against a tx core that never reports busy
                    if (tx_busy) begin
                        busy_seen_nx = 1'b1;
                    end else if (busy_seen) begin
                        state_nx = S_RECV;
                        timer_nx = LD_RESP;
                        count_nx = '0;
                        chk_nx   = 8'h00;
                    end else if (tc) begin
                        state_nx = S_IDLE;
                        timer_nx = LD_POLL;
                        err_nx   = ERR_RESP;
                        gd_nx    = 1'b0;
                    end
                end
                S_RECV: begin
                    if (tc) begin
                        state_nx = S_IDLE;
                        timer_nx = LD_POLL;
                        err_nx   = ERR_RESP;
                        gd_nx    = 1'b0;
                    end else if (rx_valid) begin
                        buf_we   = 1'b1;
                        count_nx = count + 1'b1;
                        if (count == LAST_IDX) state_nx = S_CHECK;
                        else                   chk_nx   = chk_acc ^ rx_data;
                    end
                end
                S_CHECK: begin
                    if (good) begin
                        state_nx = S_STREAM;
                        count_nx = '0;
                    end else begin
                        state_nx = S_IDLE;
                        timer_nx = LD_POLL;
                        err_nx   = ERR_FRAME;
                        gd_nx    = 1'b0;
                    end
                end
                S_STREAM: begin
                    if (count == LAST_IDX) begin
                        state_nx = S_IDLE;
                        timer_nx = LD_POLL;
                        gd_nx    = 1'b1;
                        err_nx   = ERR_NONE;
                    end else begin
                        count_nx = count + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (tc) state_nx = S_OFF;
                end
                default: state_nx = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            timer     <= '0;
            count     <= '0;
            chk_acc   <= 8'h00;
            flt_seen  <= 1'b0;
            busy_seen <= 1'b0;
            gd        <= 1'b0;
            err       <= ERR_NONE;
            maga_en   <= 1'b0;
            ready_sy  <= 2'b00;
            flt_sy    <= 2'b00;
            inv_sy    <= 2'b00;
            for (int i = 0; i < LEN; i++) rx_buf[i] <= 8'h00;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            count     <= count_nx;
            chk_acc   <= chk_nx;
            flt_seen  <= flt_seen_nx;
            busy_seen <= busy_seen_nx;
            gd        <= gd_nx;
            err       <= err_nx;
            maga_en   <= (state_nx != S_OFF) && (state_nx != S_FAULT);
            ready_sy  <= {ready_sy[0], maga_ready};
            flt_sy    <= {flt_sy[0], maga_flt};
            inv_sy    <= {inv_sy[0], maga_invalid};
            if (buf_we) rx_buf[count] <= rx_data;
        end
    end
endmodule
